// File: rtl/fifo_rd_drain_ctrl_if.sv
// Handshake bundle between the FIFO read port / UART TX and the drain controller.
// The controller uses the slave modport; the environment driving it uses master.
interface fifo_rd_drain_ctrl_if #(
    parameter int unsigned DATA_WIDTH = 8,
    parameter int unsigned CNT_WIDTH  = 8
);
    logic                  DRAIN_EN;
    logic                  EMPTY;
    logic [DATA_WIDTH-1:0] RD_DATA;
    logic                  TX_BUSY;
    logic                  R_INC;
    logic [DATA_WIDTH-1:0] TX_P_DATA;
    logic                  TX_DATA_VALID;
    logic                  TIMEOUT_ERR;
    logic [CNT_WIDTH-1:0]  BYTE_CNT;

    modport slave (
        input  DRAIN_EN,
        input  EMPTY,
        input  RD_DATA,
        input  TX_BUSY,
        output R_INC,
        output TX_P_DATA,
        output TX_DATA_VALID,
        output TIMEOUT_ERR,
        output BYTE_CNT
    );

    modport master (
        output DRAIN_EN,
        output EMPTY,
        output RD_DATA,
        output TX_BUSY,
        input  R_INC,
        input  TX_P_DATA,
        input  TX_DATA_VALID,
        input  TIMEOUT_ERR,
        input  BYTE_CNT
    );
endinterface

// File: rtl/fifo_rd_drain_ctrl.sv
// Read-domain FIFO consumer: pops one word at a time into the UART TX and
// waits for the TX busy handshake to finish before popping the next.
module fifo_rd_drain_ctrl #(
    parameter int unsigned DATA_WIDTH = 8,
    parameter int unsigned TIMEOUT    = 16,
    parameter int unsigned CNT_WIDTH  = 8
) (
    input  logic                R_CLK,
    input  logic                R_RST,
    fifo_rd_drain_ctrl_if.slave bus_if
);
    localparam int unsigned TIMER_W = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;

    typedef enum logic [1:0] {
        ST_IDLE      = 2'd0,
        ST_WAIT_BUSY = 2'd1,
        ST_WAIT_DONE = 2'd2
    } state_t;

    state_t                state_q, state_d;
    logic [TIMER_W-1:0]    timer_q, timer_d;
    logic                  r_inc_q, r_inc_d;
    logic                  valid_q, valid_d;
    logic                  err_q, err_d;
    logic [DATA_WIDTH-1:0] data_q, data_d;
    logic [CNT_WIDTH-1:0]  cnt_q, cnt_d;

    // State and output registers
    always_ff @(posedge R_CLK or negedge R_RST) begin
        if (!R_RST) begin
            state_q <= ST_IDLE;
            timer_q <= '0;
            r_inc_q <= 1'b0;
            valid_q <= 1'b0;
            err_q   <= 1'b0;
            data_q  <= '0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            timer_q <= timer_d;
            r_inc_q <= r_inc_d;
            valid_q <= valid_d;
            err_q   <= err_d;
            data_q  <= data_d;
            cnt_q   <= cnt_d;
        end
    end

    // Next-state logic; strobes default low so every pulse lasts one cycle
    always_comb begin
        state_d = state_q;
        timer_d = timer_q;
        r_inc_d = 1'b0;
        valid_d = 1'b0;
        err_d   = 1'b0;
        data_d  = data_q;
        cnt_d   = cnt_q;

        case (state_q)
            ST_IDLE: begin
                if (bus_if.DRAIN_EN && !bus_if.EMPTY && !bus_if.TX_BUSY) begin
                    data_d  = bus_if.RD_DATA;
                    r_inc_d = 1'b1;
                    valid_d = 1'b1;
                    timer_d = '0;
                    state_d = ST_WAIT_BUSY;
                end
            end
            ST_WAIT_BUSY: begin
                if (bus_if.TX_BUSY) begin
                    state_d = ST_WAIT_DONE;
                end else if (timer_q == TIMER_W'(TIMEOUT - 1)) begin
                    // TX never took the word; it is dropped, not re-popped
                    err_d   = 1'b1;
                    state_d = ST_IDLE;
                end else begin
                    timer_d = timer_q + TIMER_W'(1);
                end
            end
            ST_WAIT_DONE: begin
                if (!bus_if.TX_BUSY) begin
                    cnt_d   = cnt_q + CNT_WIDTH'(1);
                    state_d = ST_IDLE;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    assign bus_if.R_INC         = r_inc_q;
    assign bus_if.TX_DATA_VALID = valid_q;
    assign bus_if.TIMEOUT_ERR   = err_q;
    assign bus_if.TX_P_DATA     = data_q;
    assign bus_if.BYTE_CNT      = cnt_q;
endmodule

// File: tb/tb_fifo_rd_drain_ctrl.sv
// Bench for fifo_rd_drain_ctrl: queue-based FIFO and scheduled TX busy around the
// DUT, with a transfer-level reference model checked every cycle.
module tb_fifo_rd_drain_ctrl;
    localparam int unsigned DW = 8;
    localparam int unsigned TO = 16;
    localparam int unsigned CW = 8;

    logic R_CLK = 1'b0;
    logic R_RST = 1'b0;
    always #5 R_CLK = ~R_CLK;

    fifo_rd_drain_ctrl_if #(.DATA_WIDTH(DW), .CNT_WIDTH(CW)) bus ();

    fifo_rd_drain_ctrl #(.DATA_WIDTH(DW), .TIMEOUT(TO), .CNT_WIDTH(CW)) dut (
        .R_CLK  (R_CLK),
        .R_RST  (R_RST),
        .bus_if (bus)
    );

    int n_tests = 0;
    int n_fail  = 0;

    // Environment: FIFO contents, lagged EMPTY, TX busy schedule
    logic [DW-1:0] q[$];
    int  size_last = 0;
    int  cyc = 0;
    int  bs = 0, be = 0;
    int  tx_delay = 1, tx_len = 1;
    bit  drain = 1'b0, ext_busy = 1'b0;

    // Reference model: one outstanding word, its age and whether TX accepted it
    bit            m_out, m_seen;
    int            m_age, m_cnt;
    bit            exp_inc, exp_valid, exp_err;
    logic [DW-1:0] exp_data;

    // Observations
    int            n_inc = 0;
    int            last_inc_cyc = -1, last_err_cyc = -1;
    int            vcyc[$];
    logic [DW-1:0] popped[$];

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    task automatic model_reset();
        m_out = 0; m_seen = 0; m_age = 0; m_cnt = 0;
        exp_inc = 0; exp_valid = 0; exp_err = 0; exp_data = '0;
    endtask

    task automatic model_edge();
        exp_inc = 0; exp_valid = 0; exp_err = 0;
        if (!R_RST) begin
            model_reset();
        end else if (!m_out) begin
            if (bus.DRAIN_EN && !bus.EMPTY && !bus.TX_BUSY) begin
                exp_data  = bus.RD_DATA;
                exp_inc   = 1;
                exp_valid = 1;
                m_out = 1; m_seen = 0; m_age = 0;
            end
        end else if (!m_seen) begin
            if (bus.TX_BUSY) m_seen = 1;
            else begin
                m_age++;
                if (m_age == int'(TO)) begin
                    exp_err = 1;
                    m_out   = 0;
                end
            end
        end else if (!bus.TX_BUSY) begin
            m_cnt = (m_cnt + 1) % (1 << CW);
            m_out = 0;
        end
    endtask

    task automatic env_update();
        if (bus.R_INC && q.size() != 0) void'(q.pop_front());
        if (bus.TX_DATA_VALID && tx_delay >= 0) begin
            bs = cyc + tx_delay;
            be = bs + tx_len;
        end
        bus.TX_BUSY  = ext_busy || (cyc >= bs && cyc < be);
        bus.EMPTY    = (size_last == 0);
        size_last    = q.size();
        bus.RD_DATA  = (q.size() != 0) ? q[0] : DW'($urandom);
        bus.DRAIN_EN = drain;
    endtask

    task automatic step();
        @(posedge R_CLK);
        model_edge();
        @(negedge R_CLK);
        chk("r_inc",       32'(bus.R_INC),         32'(exp_inc));
        chk("tx_valid",    32'(bus.TX_DATA_VALID), 32'(exp_valid));
        chk("timeout_err", 32'(bus.TIMEOUT_ERR),   32'(exp_err));
        chk("tx_p_data",   32'(bus.TX_P_DATA),     32'(exp_data));
        chk("byte_cnt",    32'(bus.BYTE_CNT),      32'(m_cnt));
        if (bus.R_INC) begin n_inc++; last_inc_cyc = cyc; end
        if (bus.TX_DATA_VALID) begin vcyc.push_back(cyc); popped.push_back(bus.TX_P_DATA); end
        if (bus.TIMEOUT_ERR) last_err_cyc = cyc;
        env_update();
        cyc++;
    endtask

    task automatic run(input int n);
        for (int i = 0; i < n; i++) step();
    endtask

    task automatic clear_obs();
        n_inc = 0; last_inc_cyc = -1; last_err_cyc = -1;
        vcyc.delete(); popped.delete();
    endtask

    task automatic chk_outputs_zero(input string pfx);
        chk({pfx, "_r_inc"},    32'(bus.R_INC),         32'd0);
        chk({pfx, "_valid"},    32'(bus.TX_DATA_VALID), 32'd0);
        chk({pfx, "_err"},      32'(bus.TIMEOUT_ERR),   32'd0);
        chk({pfx, "_data"},     32'(bus.TX_P_DATA),     32'd0);
        chk({pfx, "_byte_cnt"}, 32'(bus.BYTE_CNT),      32'd0);
    endtask

    task automatic reset_mid();
        #2 R_RST = 1'b0;
        #1 chk_outputs_zero("rst_mid");
        model_reset();
        bs = 0; be = 0;
        step();
        R_RST = 1'b1;
    endtask

    initial begin
        bus.DRAIN_EN = 1'b0;
        bus.EMPTY    = 1'b1;
        bus.RD_DATA  = '0;
        bus.TX_BUSY  = 1'b0;
        model_reset();
        #1 chk_outputs_zero("por");
        run(2);
        R_RST = 1'b1;

        // Single word
        clear_obs();
        drain = 1; tx_delay = 1; tx_len = 10;
        q.push_back(8'hA5);
        run(30);
        chk("t1_pops",  32'(n_inc), 32'd1);
        chk("t1_data",  32'(popped[0]), 32'hA5);
        chk("t1_cnt",   32'(bus.BYTE_CNT), 32'd1);

        // Burst of three
        clear_obs();
        q.push_back(8'h01); q.push_back(8'h02); q.push_back(8'h03);
        run(60);
        chk("t2_pops", 32'(n_inc), 32'd3);
        chk("t2_seq0", 32'(popped[0]), 32'h01);
        chk("t2_seq1", 32'(popped[1]), 32'h02);
        chk("t2_seq2", 32'(popped[2]), 32'h03);
        chk("t2_cnt",  32'(bus.BYTE_CNT), 32'd4);

        // Timeout, then the next word pops on the following edge
        clear_obs();
        tx_delay = -1;
        q.push_back(8'h3C); q.push_back(8'h4D);
        for (int i = 0; i < 40 && last_err_cyc < 0; i++) step();
        chk("t3_cnt_at_err", 32'(bus.BYTE_CNT), 32'd4);
        tx_delay = 1; tx_len = 3;
        run(20);
        chk("t3_pops",     32'(vcyc.size()), 32'd2);
        chk("t3_err_lat",  32'(last_err_cyc - vcyc[0]), 32'(TO));
        chk("t3_next_pop", 32'(vcyc[1] - last_err_cyc), 32'd1);
        chk("t3_next_dat", 32'(popped[1]), 32'h4D);
        chk("t3_cnt",      32'(bus.BYTE_CNT), 32'd5);

        // Gating: DRAIN_EN low, then dropped during WAIT_DONE
        clear_obs();
        drain = 0;
        q.push_back(8'h77);
        run(50);
        chk("t4_gated", 32'(n_inc), 32'd0);
        drain = 1; tx_delay = 1; tx_len = 5;
        q.push_back(8'h88);
        for (int i = 0; i < 10 && vcyc.size() == 0; i++) step();
        run(2);
        drain = 0;
        run(30);
        chk("t4_pops",  32'(n_inc), 32'd1);
        chk("t4_cnt",   32'(bus.BYTE_CNT), 32'd6);
        chk("t4_left",  32'(q.size()), 32'd1);
        q.delete();
        run(3);

        // TX busy already high in IDLE
        clear_obs();
        ext_busy = 1; drain = 1; tx_delay = 1; tx_len = 3;
        q.push_back(8'h5A);
        run(10);
        chk("t5_held", 32'(n_inc), 32'd0);
        ext_busy = 0;
        step();
        chk("t5_not_yet", 32'(n_inc), 32'd0);
        step();
        chk("t5_pop", 32'(n_inc), 32'd1);
        run(15);
        chk("t5_cnt", 32'(bus.BYTE_CNT), 32'd7);

        // Reset in WAIT_DONE, then 256 transfers to wrap the counter
        clear_obs();
        tx_delay = 1; tx_len = 10;
        q.push_back(8'hC3);
        for (int i = 0; i < 10 && vcyc.size() == 0; i++) step();
        run(3);
        reset_mid();
        clear_obs();
        tx_delay = 0; tx_len = 1;
        for (int i = 0; i < 256; i++) q.push_back(DW'(i));
        run(800);
        chk("t6_pops",   32'(n_inc), 32'd256);
        chk("t6_wrap",   32'(bus.BYTE_CNT), 32'd0);
        chk("t6_last",   32'(popped[255]), 32'hFF);
        q.push_back(8'h99);
        run(10);
        chk("t6_after",  32'(bus.BYTE_CNT), 32'd1);

        // Randomized traffic
        for (int i = 0; i < 3000; i++) begin
            if ($urandom_range(0, 3) == 0 && q.size() < 8) q.push_back(DW'($urandom));
            drain    = ($urandom_range(0, 9) != 0);
            ext_busy = ($urandom_range(0, 19) == 0);
            tx_delay = ($urandom_range(0, 9) == 0) ? -1 : int'($urandom_range(0, 18));
            tx_len   = int'($urandom_range(1, 6));
            step();
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
